decimal_entry_to_bin: RTL and testbench
=======================================

// Module: decimal_entry_to_bin
// PURPOSE
//  Player-input path of the matching game, in the opposite direction to the display path.
//  The display path splits a binary value into tens/ones digits for the 7-seg displays.
//  This block collects up to two decimal digits, one per debounced button press.
//  It assembles them into a binary value 0..MAX_VAL, offers the value to game logic on a
//  valid/ready handshake, and echoes the digits typed so far so they can be shown on 7-seg.
// PARAMETERS
//  DIGIT_W  4    width of one BCD digit
//  VAL_W    7    width of assembled binary value (holds 0..99)
//  MAX_VAL  99   largest value accepted on commit; larger entries are rejected
// PORTS
//  clk        in   1        single clock; all state on rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  digit      in   DIGIT_W  BCD digit from switches, sampled only when digit_stb=1
//  digit_stb  in   1        one-cycle pulse: enter digit
//  back_stb   in   1        one-cycle pulse: delete last digit
//  enter_stb  in   1        one-cycle pulse: commit entry
//  clear_stb  in   1        one-cycle pulse: discard entry / abort pending value
//  val        out  VAL_W    committed binary value, stable while val_valid=1
//  val_valid  out  1        committed value available
//  val_ready  in   1        consumer accepts val when val_valid&val_ready
//  disp_tens  out  DIGIT_W  tens digit to show (0 when not present)
//  disp_ones  out  DIGIT_W  ones digit to show (0 when not present)
//  disp_cnt   out  2        digits currently entered (0,1,2); display blanks absent digits
//  err        out  1        one-cycle pulse on any rejected event
// BEHAVIOUR
//  Reset (async, rst_n=0): state EMPTY; val=0, val_valid=0, disp_*=0, disp_cnt=0, err=0.
//    This applies even mid-entry or with val_valid pending; the pending value is lost.
//  States:
//    EMPTY  - no digits
//    ONE    - d0 held
//    TWO    - d0=tens, d1=ones
//    HOLD   - val_valid=1, waiting for val_ready
//  Event priority within a cycle: clear > enter > back > digit.
//    Lower-priority strobes in the same cycle are dropped silently, with no err.
//  digit_stb:
//    digit>9                 -> err pulse, no state change
//    EMPTY                   -> ONE
//    ONE                     -> TWO; first digit becomes tens
//    TWO                     -> err pulse, entry unchanged (no shift-out)
//    HOLD                    -> ignored, no err
//  back_stb:
//    TWO                     -> ONE
//    ONE                     -> EMPTY
//    EMPTY                   -> ignored
//    HOLD                    -> ignored
//  enter_stb:
//    EMPTY                   -> err pulse
//    ONE                     -> val = d0
//    TWO                     -> val = tens*10 + ones
//    HOLD                    -> ignored
//    Result > MAX_VAL        -> err pulse, entry kept
//    Otherwise               -> HOLD; val and val_valid registered, so val_valid rises
//                               the cycle after enter_stb (latency 1)
//  HOLD:
//    val_valid & val_ready   -> EMPTY next cycle; val_valid=0; disp cleared
//    val_ready high in the same cycle val_valid rises counts as acceptance (1-cycle hold)
//    val and disp_* remain stable until acceptance
//  clear_stb:
//    any state               -> EMPTY next cycle; val_valid drops with no handshake
//  Arithmetic:
//    tens*10 computed as (tens<<3)+(tens<<1), zero-extended to VAL_W; no overflow for 99
//  disp_* and disp_cnt are registered and follow state with no extra latency.
// STRUCTURE
//  Shared package game_pkg:
//    entry_state_t enum {EMPTY,ONE,TWO,HOLD}
//    localparams BCD_MAX=9, DIGIT_W, VAL_W
//  One combinational sub-module bcd2_to_bin:
//    inputs (tens, ones, ndigits) -> binary value
//    reused by the scoring logic
//  FSM, digit registers and handshake stay in this module.
// TESTING
//  1. Reset, digits 4 then 7, enter, val_ready=1
//       -> val_valid rises 1 cycle after enter with val=47; EMPTY next cycle
//  2. Digit 5, enter, val_ready held 0 for 6 cycles
//       -> val=5, val_valid=1 and stable all 6 cycles; digit strobes ignored; err=0
//  3. Digit 12, or digit with disp_cnt=2, or enter with disp_cnt=0
//       -> err one-cycle pulse each time; disp_* unchanged
//  4. MAX_VAL=50: digits 6,3, enter -> err pulse, still TWO; back -> disp_cnt=1, disp_ones=0;
//     digit 2, enter -> val=62 rejected; clear -> EMPTY
//  5. digit_stb and clear_stb in same cycle -> EMPTY, no err;
//     enter_stb and back_stb together in TWO -> commit wins
//  6. rst_n low asynchronously mid-cycle while in HOLD
//       -> val_valid=0, val=0 immediately, without a clock edge

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and widths for the matching-game datapath.
// Used by the player-input path and the scoring logic.
package game_pkg;
    localparam int BCD_MAX = 9;
    localparam int DIGIT_W = 4;
    localparam int VAL_W   = 7;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2,
        HOLD  = 2'd3
    } entry_state_t;
endpackage

// File: rtl/bcd2_to_bin.sv
// Combinational two-digit BCD to binary; a single held digit sits in tens.
// Shared with the scoring logic.
module bcd2_to_bin #(
    parameter int DIGIT_W = game_pkg::DIGIT_W,
    parameter int VAL_W   = game_pkg::VAL_W
) (
    input  logic [DIGIT_W-1:0] tens,
    input  logic [DIGIT_W-1:0] ones,
    input  logic [1:0]         ndigits,
    output logic [VAL_W-1:0]   bin
);
    logic [VAL_W-1:0] t_ext;
    logic [VAL_W-1:0] o_ext;

    assign t_ext = VAL_W'(tens);
    assign o_ext = VAL_W'(ones);

    always_comb begin
        bin = '0;
        case (ndigits)
            2'd1:    bin = t_ext;
            // x*10 as shift-add; 99 fits in 7 bits
            2'd2:    bin = (t_ext << 3) + (t_ext << 1) + o_ext;
            default: bin = '0;
        endcase
    end
endmodule

// File: rtl/decimal_entry_to_bin.sv
// Collects up to two decimal digits from button strobes, commits them as a binary
// value on a valid/ready handshake, and echoes the digits for the 7-seg display.
module decimal_entry_to_bin
    import game_pkg::*;
#(
    parameter int DIGIT_W = game_pkg::DIGIT_W,
    parameter int VAL_W   = game_pkg::VAL_W,
    parameter int MAX_VAL = 99
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               digit_stb,
    input  logic               back_stb,
    input  logic               enter_stb,
    input  logic               clear_stb,
    output logic [VAL_W-1:0]   val,
    output logic               val_valid,
    input  logic               val_ready,
    output logic [DIGIT_W-1:0] disp_tens,
    output logic [DIGIT_W-1:0] disp_ones,
    output logic [1:0]         disp_cnt,
    output logic               err
);
    entry_state_t     state;
    logic [VAL_W-1:0] asm_val;
    logic             too_big;
    logic             bad_digit;

    bcd2_to_bin #(.DIGIT_W(DIGIT_W), .VAL_W(VAL_W)) u_conv (
        .tens    (disp_tens),
        .ones    (disp_ones),
        .ndigits (disp_cnt),
        .bin     (asm_val)
    );

    assign too_big   = int'(asm_val) > MAX_VAL;
    assign bad_digit = digit > DIGIT_W'(BCD_MAX);

    // Branch order encodes clear > handshake/HOLD > enter > back > digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            val       <= '0;
            val_valid <= 1'b0;
            disp_tens <= '0;
            disp_ones <= '0;
            disp_cnt  <= 2'd0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            if (clear_stb || (state == HOLD && val_ready)) begin
                state     <= EMPTY;
                val       <= '0;
                val_valid <= 1'b0;
                disp_tens <= '0;
                disp_ones <= '0;
                disp_cnt  <= 2'd0;
            end else if (state == HOLD) begin
                // entry frozen until the consumer takes it
                state <= HOLD;
            end else if (enter_stb) begin
                if (state == EMPTY || too_big) begin
                    err <= 1'b1;
                end else begin
                    state     <= HOLD;
                    val       <= asm_val;
                    val_valid <= 1'b1;
                end
            end else if (back_stb) begin
                case (state)
                    TWO: begin
                        state     <= ONE;
                        disp_ones <= '0;
                        disp_cnt  <= 2'd1;
                    end
                    ONE: begin
                        state     <= EMPTY;
                        disp_tens <= '0;
                        disp_cnt  <= 2'd0;
                    end
                    default: state <= state;
                endcase
            end else if (digit_stb) begin
                if (bad_digit) begin
                    err <= 1'b1;
                end else begin
                    case (state)
                        EMPTY: begin
                            state     <= ONE;
                            disp_tens <= digit;
                            disp_cnt  <= 2'd1;
                        end
                        ONE: begin
                            state     <= TWO;
                            disp_ones <= digit;
                            disp_cnt  <= 2'd2;
                        end
                        default: err <= 1'b1;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_decimal_entry_to_bin.sv
// Directed table-driven bench for decimal_entry_to_bin, plus hand sequences for
// a reduced MAX_VAL instance and asynchronous reset while a value is pending.
module tb_decimal_entry_to_bin;
    localparam logic [3:0] N = 4'd0, D = 4'd1, B = 4'd2, E = 4'd4, C = 4'd8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] digit = '0;
    logic       digit_stb = 1'b0, back_stb = 1'b0, enter_stb = 1'b0, clear_stb = 1'b0;
    logic       val_ready = 1'b0;

    logic [6:0] val, val50;
    logic       val_valid, val_valid50;
    logic [3:0] disp_tens, disp_ones, disp_tens50, disp_ones50;
    logic [1:0] disp_cnt, disp_cnt50;
    logic       err, err50;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decimal_entry_to_bin dut (
        .clk(clk), .rst_n(rst_n), .digit(digit), .digit_stb(digit_stb),
        .back_stb(back_stb), .enter_stb(enter_stb), .clear_stb(clear_stb),
        .val(val), .val_valid(val_valid), .val_ready(val_ready),
        .disp_tens(disp_tens), .disp_ones(disp_ones), .disp_cnt(disp_cnt), .err(err)
    );

    decimal_entry_to_bin #(.MAX_VAL(50)) dut50 (
        .clk(clk), .rst_n(rst_n), .digit(digit), .digit_stb(digit_stb),
        .back_stb(back_stb), .enter_stb(enter_stb), .clear_stb(clear_stb),
        .val(val50), .val_valid(val_valid50), .val_ready(val_ready),
        .disp_tens(disp_tens50), .disp_ones(disp_ones50), .disp_cnt(disp_cnt50), .err(err50)
    );

    typedef struct {
        logic [3:0] stb;
        logic [3:0] d;
        logic       rdy;
        logic [1:0] cnt;
        logic [3:0] t;
        logic [3:0] o;
        logic       e;
        logic       vv;
        logic [6:0] v;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic [3:0] stb, logic [3:0] d, logic rdy, logic [1:0] cnt,
                                logic [3:0] t, logic [3:0] o, logic e, logic vv, logic [6:0] v);
        vec_t r;
        r.stb = stb; r.d = d; r.rdy = rdy; r.cnt = cnt; r.t = t; r.o = o;
        r.e = e; r.vv = vv; r.v = v;
        return r;
    endfunction

    // One clock with the given strobes; outputs are sampled 1 time unit after the edge.
    task automatic apply(input logic [3:0] stb, input logic [3:0] d, input logic rdy);
        digit     = d;
        digit_stb = stb[0];
        back_stb  = stb[1];
        enter_stb = stb[2];
        clear_stb = stb[3];
        val_ready = rdy;
        @(posedge clk);
        #1;
        digit_stb = 1'b0; back_stb = 1'b0; enter_stb = 1'b0; clear_stb = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // test 1: 47 with ready already high
        tv.push_back(mk(D, 4, 0, 1, 4, 0, 0, 0, 0));
        tv.push_back(mk(D, 7, 0, 2, 4, 7, 0, 0, 0));
        tv.push_back(mk(E, 0, 1, 2, 4, 7, 0, 1, 47));
        tv.push_back(mk(N, 0, 1, 0, 0, 0, 0, 0, 0));
        // test 2: 5 held for six cycles, strobes ignored
        tv.push_back(mk(D, 5, 0, 1, 5, 0, 0, 0, 0));
        tv.push_back(mk(E, 0, 0, 1, 5, 0, 0, 1, 5));
        tv.push_back(mk(D, 3, 0, 1, 5, 0, 0, 1, 5));
        tv.push_back(mk(N, 0, 0, 1, 5, 0, 0, 1, 5));
        tv.push_back(mk(D, 8, 0, 1, 5, 0, 0, 1, 5));
        tv.push_back(mk(B, 0, 0, 1, 5, 0, 0, 1, 5));
        tv.push_back(mk(E, 0, 0, 1, 5, 0, 0, 1, 5));
        tv.push_back(mk(D, 12, 0, 1, 5, 0, 0, 1, 5));
        tv.push_back(mk(N, 0, 1, 0, 0, 0, 0, 0, 0));
        // test 3: rejected events
        tv.push_back(mk(D, 12, 0, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(E, 0, 0, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(D, 1, 0, 1, 1, 0, 0, 0, 0));
        tv.push_back(mk(D, 2, 0, 2, 1, 2, 0, 0, 0));
        tv.push_back(mk(D, 3, 0, 2, 1, 2, 1, 0, 0));
        tv.push_back(mk(D, 15, 0, 2, 1, 2, 1, 0, 0));
        tv.push_back(mk(N, 0, 0, 2, 1, 2, 0, 0, 0));
        // test 5: priority, and 99 boundary
        tv.push_back(mk(C|D, 4, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(D, 9, 0, 1, 9, 0, 0, 0, 0));
        tv.push_back(mk(D, 9, 0, 2, 9, 9, 0, 0, 0));
        tv.push_back(mk(E|B, 0, 0, 2, 9, 9, 0, 1, 99));
        tv.push_back(mk(C, 0, 0, 0, 0, 0, 0, 0, 0));
        // back handling, value 0, back beats digit
        tv.push_back(mk(D, 3, 0, 1, 3, 0, 0, 0, 0));
        tv.push_back(mk(B, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(B, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(D, 0, 0, 1, 0, 0, 0, 0, 0));
        tv.push_back(mk(E, 0, 0, 1, 0, 0, 0, 1, 0));
        tv.push_back(mk(N, 0, 1, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(D, 5, 0, 1, 5, 0, 0, 0, 0));
        tv.push_back(mk(B|D, 6, 0, 0, 0, 0, 0, 0, 0));

        #12;
        chk("reset", {25'd0, val_valid, val}, 32'd0);
        chk("reset_disp", {21'd0, err, disp_cnt, disp_tens, disp_ones}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < tv.size(); i++) begin
            apply(tv[i].stb, tv[i].d, tv[i].rdy);
            total++;
            if ({disp_cnt, disp_tens, disp_ones, err, val_valid, val} !==
                {tv[i].cnt, tv[i].t, tv[i].o, tv[i].e, tv[i].vv, tv[i].v}) begin
                bad++;
                $display("FAIL vec%0d: got cnt=%0d t=%0d o=%0d err=%b vv=%b val=%0d expected cnt=%0d t=%0d o=%0d err=%b vv=%b val=%0d",
                         i, disp_cnt, disp_tens, disp_ones, err, val_valid, val,
                         tv[i].cnt, tv[i].t, tv[i].o, tv[i].e, tv[i].vv, tv[i].v);
            end
        end

        // test 4: MAX_VAL=50 instance
        apply(C, 0, 0);
        apply(D, 6, 0);
        apply(D, 3, 0);
        apply(E, 0, 0);
        chk("m50_63_err", {err50, val_valid50, disp_cnt50}, {1'b1, 1'b0, 2'd2});
        apply(B, 0, 0);
        chk("m50_back", {err50, disp_cnt50, disp_tens50, disp_ones50}, {1'b0, 2'd1, 4'd6, 4'd0});
        apply(D, 2, 0);
        chk("m50_62", {disp_cnt50, disp_tens50, disp_ones50}, {2'd2, 4'd6, 4'd2});
        apply(E, 0, 0);
        chk("m50_62_err", {err50, val_valid50, disp_cnt50}, {1'b1, 1'b0, 2'd2});
        apply(C, 0, 0);
        chk("m50_clear", {err50, val_valid50, disp_cnt50}, {1'b0, 1'b0, 2'd0});
        apply(D, 5, 0);
        apply(D, 0, 0);
        apply(E, 0, 0);
        chk("m50_50_ok", {err50, val_valid50, val50}, {1'b0, 1'b1, 7'd50});
        apply(N, 0, 1);
        chk("m50_accept", {val_valid50, disp_cnt50}, {1'b0, 2'd0});

        // test 6: async reset while holding
        apply(D, 4, 0);
        apply(E, 0, 0);
        chk("hold_pre_rst", {val_valid, val}, {1'b1, 7'd4});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {val_valid, val, disp_cnt, disp_tens}, {1'b0, 7'd0, 2'd0, 4'd0});
        @(negedge clk);
        rst_n = 1'b1;
        apply(D, 8, 0);
        chk("post_rst", {disp_cnt, disp_tens, err}, {2'd1, 4'd8, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
